// File: rtl/custom_function.sv
// rtl/custom_function.sv - generate-selected two-input bitwise logic unit with registered copy
module custom_function #(
    parameter int f     = 0,
    parameter int WIDTH = 1
) (
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] Y_q,
    output logic             f_err
);

    localparam bit F_UNSUPPORTED = (f < 0) || (f > 7);

    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;

    // Exactly one operator is elaborated; f is never a runtime select.
    generate
        case (f)
            0: begin : g_and
                assign Y = A & B;
            end
            1: begin : g_or
                assign Y = A | B;
            end
            2: begin : g_xor
                assign Y = A ^ B;
            end
            3: begin : g_nand
                assign Y = ~(A & B);
            end
            4: begin : g_nor
                assign Y = ~(A | B);
            end
            5: begin : g_xnor
                assign Y = ~(A ^ B);
            end
            6: begin : g_andn
                assign Y = A & ~B;
            end
            7: begin : g_orn
                assign Y = A | ~B;
            end
            default: begin : g_unsupported
                logic unused_inputs;
                assign unused_inputs = ^{A, B};
                assign Y = '0;
                $warning("custom_function: unsupported function select f=%0d, outputs forced to zero", f);
            end
        endcase
    endgenerate

    assign f_err = F_UNSUPPORTED;

    always_comb begin
        res_d = F_UNSUPPORTED ? '0 : Y;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign Y_q = res_q;

endmodule

// File: tb/tb_custom_function.sv
// tb/tb_custom_function.sv - self-checking bench for custom_function
`timescale 1ns/1ps
module tb_custom_function;

    typedef struct {
        logic       a;
        logic       b;
        logic [7:0] y;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
    } vec8_t;

    logic clk = 1'b0;
    logic rst_n;

    logic       a1, b1;
    wire  [7:0] y1, yq1, ferr1;

    logic [7:0] xa, xb;
    wire  [7:0] xy, xyq;
    wire        xferr;

    logic [7:0] ra, rb;
    wire  [7:0] ry, ryq;
    wire        rferr;

    logic [7:0] ba, bb;
    wire  [7:0] by, byq;
    wire        bferr;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    vec1_t t1[4];
    vec8_t t8[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 8; g++) begin : g_w1
        custom_function #(.f(g), .WIDTH(1)) u_fn (
            .Y(y1[g]), .A(a1), .B(b1), .clk(clk), .rst_n(rst_n),
            .Y_q(yq1[g]), .f_err(ferr1[g])
        );
    end

    custom_function #(.f(2), .WIDTH(8)) u_xor8 (
        .Y(xy), .A(xa), .B(xb), .clk(clk), .rst_n(rst_n), .Y_q(xyq), .f_err(xferr)
    );

    custom_function #(.f(0), .WIDTH(8)) u_reg8 (
        .Y(ry), .A(ra), .B(rb), .clk(clk), .rst_n(rst_n), .Y_q(ryq), .f_err(rferr)
    );

    custom_function #(.f(9), .WIDTH(8)) u_bad8 (
        .Y(by), .A(ba), .B(bb), .clk(clk), .rst_n(rst_n), .Y_q(byq), .f_err(bferr)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Expected bit g is the result of function g for that {A,B} vector.
        t1[0] = '{1'b0, 1'b0, 8'hB8};
        t1[1] = '{1'b0, 1'b1, 8'h0E};
        t1[2] = '{1'b1, 1'b0, 8'hCE};
        t1[3] = '{1'b1, 1'b1, 8'hA3};
        t8[0] = '{8'hA5, 8'h0F, 8'hAA};
        t8[1] = '{8'hFF, 8'hFF, 8'h00};
        t8[2] = '{8'h00, 8'hFF, 8'hFF};

        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        xa = 8'h00; xb = 8'h00;
        ra = 8'h00; rb = 8'h00;
        ba = 8'h00; bb = 8'h00;
        #1;

        check("rst_y_q_w8", ryq, 8'h00);
        check("rst_y_q_w1", yq1, 8'h00);
        check("rst_y_q_bad", byq, 8'h00);
        check("f_err_supported_w1", ferr1, 8'h00);
        check("f_err_f0_w8", {7'b0, rferr}, 8'h00);
        check("f_err_f2_w8", {7'b0, xferr}, 8'h00);
        check("f_err_f9", {7'b0, bferr}, 8'h01);

        // Combinational sweeps run while reset is held: Y must ignore rst_n.
        for (int i = 0; i < 4; i++) begin
            a1 = t1[i].a;
            b1 = t1[i].b;
            #0.01;
            check($sformatf("w1_vec%0d", i), y1, t1[i].y);
        end

        for (int i = 0; i < 3; i++) begin
            xa = t8[i].a; xb = t8[i].b;
            ba = t8[i].a; bb = t8[i].b;
            #0.01;
            check($sformatf("xor8_vec%0d", i), xy, t8[i].y);
            check($sformatf("bad_y_vec%0d", i), by, 8'h00);
        end

        @(negedge clk);
        ra = 8'hF0; rb = 8'h3C;
        #0.01;
        check("reg_y_comb", ry, 8'h30);
        @(posedge clk);
        #1;
        check("reg_y_q_held_in_reset", ryq, 8'h00);

        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(8'h30);
        #1;
        check("reg_y_q_before_edge", ryq, 8'h00);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got empty queue expected one entry");
        end else begin
            check("reg_y_q_first_capture", ryq, exp_q.pop_front());
        end

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            ba = 8'($urandom);
            bb = 8'($urandom);
            exp_q.push_back(ra & rb);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_empty: got empty queue expected one entry");
            end else begin
                check($sformatf("sb_y_q_%0d", i), ryq, exp_q.pop_front());
            end
            check($sformatf("bad_y_q_%0d", i), byq, 8'h00);
            check($sformatf("bad_y_%0d", i), by, 8'h00);
        end

        // a1=b1=1 has been stable across many edges since reset release.
        check("w1_y_q_all_funcs", yq1, 8'hA3);

        @(negedge clk);
        ra = 8'hF0; rb = 8'hC3;
        @(posedge clk);
        #1;
        check("reg_y_q_pre_midreset", ryq, 8'hC0);
        ra = 8'hF0; rb = 8'h3C;
        #2;
        rst_n = 1'b0;
        #0.01;
        check("midreset_y_q_async", ryq, 8'h00);
        check("midreset_y_unaffected", ry, 8'h30);
        @(posedge clk);
        #1;
        check("midreset_y_q_stays_low", ryq, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
